// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed RISC-V load/store data memory with fixed-latency response
module data_mem_ctrl #(
  parameter int ADDR_W = 10,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_func3,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [1:0] cnt, cnt_n;
  logic [7:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] ad [4];
  logic [1:0] size;
  logic [3:0] be;
  logic accept, ill, mis, err, wr;
  logic [31:0] b, ld, rdata_q;
  logic err_q;
  // byte addresses of the access, wrapping at the top of the array
  always_comb begin
    for (int k = 0; k < 4; k++) ad[k] = req_addr + ADDR_W'(k);
  end
  // decode access size, legality, alignment and the extended load value
  always_comb begin
    size = req_func3[1:0];
    ill = req_we ? (req_func3 > 3'd2) : (req_func3 == 3'd3 || req_func3[2:1] == 2'b11);
    mis = (size == 2'd1 && req_addr[0]) || (size == 2'd2 && req_addr[1:0] != 2'b00);
    err = ill | mis;
    be = size == 2'd0 ? 4'b0001 : size == 2'd1 ? 4'b0011 : 4'b1111;
    accept = req_valid & req_ready;
    wr = accept & req_we & ~err;
    b = {mem[ad[3]], mem[ad[2]], mem[ad[1]], mem[ad[0]]};
    ld = size == 2'd0 ? {{24{b[7] & ~req_func3[2]}}, b[7:0]} :
         size == 2'd1 ? {{16{b[15] & ~req_func3[2]}}, b[15:0]} : b;
  end
  // store commit at the accept edge; the array is never reset
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (!rst && wr && be[k]) mem[ad[k]] <= req_wdata[8*k +: 8];
  end
  // next state and latency down-counter
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (accept) begin
        state_n = LATENCY > 1 ? WAIT : RESP;
        cnt_n = 2'(LATENCY > 1 ? LATENCY - 2 : 0);
      end
      WAIT: if (cnt == 2'd0) state_n = RESP; else cnt_n = cnt - 2'd1;
      default: state_n = IDLE;
    endcase
  end
  // state, counter and response capture registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 2'd0;
      rdata_q <= 32'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) begin
        rdata_q <= (req_we || err) ? 32'd0 : ld;
        err_q <= err;
      end
    end
  end
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
  assign rsp_err = rsp_valid & err_q;
endmodule
